// File: rtl/systolic_seq.sv
// systolic_seq: start/run sequencer for a ROWS x COLS systolic array.
// Drives skewed left-edge (row_en) and top-edge (col_en) enables so that
// PE(i,j) sees both operands for i+j <= t < i+j+K, then pulses done.
// Optional feature: define SYSTOLIC_SEQ_PERF_CNT_EN to build the saturating
// busy-cycle counter behind perf_cycles; otherwise perf_cycles is tied to 0.
module systolic_seq #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned KW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            start_ready,
  output logic            busy,
  output logic            done,
  output logic            acc_clr,
  output logic [ROWS-1:0] row_en,
  output logic [COLS-1:0] col_en,
  output logic [31:0]     perf_cycles
);

  // t must reach ROWS+COLS+K-2 with K = 2^KW-1 without wrapping, and the
  // per-lane upper bound i+K must also fit.
  localparam int unsigned TW = KW + $clog2(ROWS + COLS) + 1;
  localparam logic [TW-1:0] SPAN = TW'(ROWS + COLS - 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   t_q, t_n;
  logic [KW-1:0]   k_q, k_n;

  logic [TW-1:0]   k_ext;
  logic [TW-1:0]   t_last;
  logic            run;
  logic            at_last;

  assign run     = (state_q == RUN);
  assign k_ext   = TW'(k_q);
  assign t_last  = SPAN + k_ext;
  assign at_last = run && (t_q == t_last);

  // State, step counter and latched operand length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_n;
      t_q     <= t_n;
      k_q     <= k_n;
    end
  end

  // Next-state: accept a non-empty start in IDLE unless abort is also
  // asserted; leave RUN on abort or after the last step.
  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    k_n     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort && (k_len != '0)) begin
          state_n = RUN;
          t_n     = '0;
          k_n     = k_len;
        end
      end
      RUN: begin
        if (abort || at_last) begin
          state_n = IDLE;
          t_n     = '0;
        end else begin
          t_n = t_q + TW'(1);
        end
      end
    endcase
  end

  // Outputs decode from registered state only; done still pulses when abort
  // lands on the last step because it reflects t, not the abort input.
  always_comb begin
    start_ready = !run;
    busy        = run;
    done        = at_last;
    acc_clr     = run && (t_q == '0);
    row_en      = '0;
    col_en      = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      row_en[i] = run && (t_q >= TW'(i)) && (t_q < (TW'(i) + k_ext));
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      col_en[j] = run && (t_q >= TW'(j)) && (t_q < (TW'(j) + k_ext));
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles; cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (run && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq (4x4, KW=8). Expected perf_cycles depends
// on whether SYSTOLIC_SEQ_PERF_CNT_EN is defined for the build.
module tb_systolic_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  k_len;
  logic        abort;
  logic        start_ready;
  logic        busy;
  logic        done;
  logic        acc_clr;
  logic [3:0]  row_en;
  logic [3:0]  col_en;
  logic [31:0] perf_cycles;

  int n_vec;
  int n_err;
  int dcnt;

  logic [3:0] en3 [0:10];
  logic [3:0] en1 [0:7];

  systolic_seq #(.ROWS(4), .COLS(4), .KW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .abort      (abort),
    .start_ready(start_ready),
    .busy       (busy),
    .done       (done),
    .acc_clr    (acc_clr),
    .row_en     (row_en),
    .col_en     (col_en),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_perf);
    chk({tag, "_ready"}, {31'd0, start_ready}, 32'd1);
    chk({tag, "_busy"},  {31'd0, busy},        32'd0);
    chk({tag, "_done"},  {31'd0, done},        32'd0);
    chk({tag, "_clr"},   {31'd0, acc_clr},     32'd0);
    chk({tag, "_row"},   {28'd0, row_en},      32'd0);
    chk({tag, "_col"},   {28'd0, col_en},      32'd0);
    chk({tag, "_perf"},  perf_cycles,          exp_perf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] perf_exp;
    n_vec = 0;
    n_err = 0;
    // Hand-derived enables for K=3: lane i on for i <= t < i+3.
    en3[0] = 4'b0001; en3[1] = 4'b0011; en3[2] = 4'b0111; en3[3]  = 4'b1110;
    en3[4] = 4'b1100; en3[5] = 4'b1000; en3[6] = 4'b0000; en3[7]  = 4'b0000;
    en3[8] = 4'b0000; en3[9] = 4'b0000; en3[10] = 4'b0000;
    // K=1: one lane per step.
    en1[0] = 4'b0001; en1[1] = 4'b0010; en1[2] = 4'b0100; en1[3] = 4'b1000;
    en1[4] = 4'b0000; en1[5] = 4'b0000; en1[6] = 4'b0000; en1[7] = 4'b0000;

    rst = 1'b1; start = 1'b0; k_len = 8'd0; abort = 1'b0;
    tick();
    tick();
    chk_idle("reset", 32'd0);
    rst = 1'b0;
    tick();

    // K=3 run: done at t=9, ready again at t=10.
    start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      chk($sformatf("k3_row_t%0d", t), {28'd0, row_en}, {28'd0, en3[t]});
      chk($sformatf("k3_col_t%0d", t), {28'd0, col_en}, {28'd0, en3[t]});
      chk($sformatf("k3_clr_t%0d", t), {31'd0, acc_clr}, (t == 0) ? 32'd1 : 32'd0);
      chk($sformatf("k3_done_t%0d", t), {31'd0, done}, (t == 9) ? 32'd1 : 32'd0);
      chk($sformatf("k3_busy_t%0d", t), {31'd0, busy}, (t <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("k3_rdy_t%0d", t), {31'd0, start_ready}, (t == 10) ? 32'd1 : 32'd0);
      if (t < 10) tick();
    end

    // start with k_len=0 is ignored.
    start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("k0_busy_%0d", n), {31'd0, busy}, 32'd0);
      chk($sformatf("k0_rdy_%0d", n),  {31'd0, start_ready}, 32'd1);
      chk($sformatf("k0_row_%0d", n),  {28'd0, row_en}, 32'd0);
      chk($sformatf("k0_done_%0d", n), {31'd0, done}, 32'd0);
      tick();
    end

    // Second start at t=2 of a K=3 run is ignored: exactly one done.
    start = 1'b1; k_len = 8'd3;
    tick();
    dcnt = 0;
    for (int t = 0; t <= 10; t++) begin
      if (done) dcnt++;
      start = (t == 2);
      k_len = (t == 2) ? 8'd5 : 8'd3;
      tick();
    end
    start = 1'b0;
    chk("restart_done_cnt", dcnt, 32'd1);
    chk("restart_ready", {31'd0, start_ready}, 32'd1);

    // New K=1 run after done is accepted; abort on its done cycle still
    // produces the done pulse.
    start = 1'b1; k_len = 8'd1;
    tick();
    start = 1'b0;
    chk("k1_busy", {31'd0, busy}, 32'd1);
    chk("k1_clr", {31'd0, acc_clr}, 32'd1);
    for (int t = 0; t < 7; t++) tick();
    chk("k1_abort_done", {31'd0, done}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("k1_abort_ready", {31'd0, start_ready}, 32'd1);
    chk("k1_abort_busy", {31'd0, busy}, 32'd0);

    // Abort at t=4 of a K=5 run.
    start = 1'b1; k_len = 8'd5;
    tick();
    start = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    chk("k5_row_t4", {28'd0, row_en}, 32'hF);
    chk("k5_col_t4", {28'd0, col_en}, 32'hF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("k5_abort_row",  {28'd0, row_en}, 32'd0);
    chk("k5_abort_col",  {28'd0, col_en}, 32'd0);
    chk("k5_abort_busy", {31'd0, busy}, 32'd0);
    chk("k5_abort_done", {31'd0, done}, 32'd0);
    chk("k5_abort_rdy",  {31'd0, start_ready}, 32'd1);

    // Following K=1 run: done at t=7.
    start = 1'b1; k_len = 8'd1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      chk($sformatf("k1_row_t%0d", t), {28'd0, row_en}, {28'd0, en1[t]});
      chk($sformatf("k1_done_t%0d", t), {31'd0, done}, (t == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk("k1_end_rdy", {31'd0, start_ready}, 32'd1);

    // abort beats start in IDLE.
    start = 1'b1; k_len = 8'd3; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    chk("abort_start_rdy", {31'd0, start_ready}, 32'd1);
    chk("abort_start_clr", {31'd0, acc_clr}, 32'd0);

    // rst at t=3 of a K=3 run.
    start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    chk("rst_row_t3", {28'd0, row_en}, 32'hE);
    rst = 1'b1;
    tick();
    chk_idle("midrst", 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("postrst", 32'd0);

    // Two back-to-back K=2 runs: done at t=8 each, 9 busy cycles each.
    for (int r = 0; r < 2; r++) begin
      start = 1'b1; k_len = 8'd2;
      tick();
      start = 1'b0;
      for (int t = 0; t <= 8; t++) begin
        if (t == 7) chk($sformatf("k2_r%0d_done_t7", r), {31'd0, done}, 32'd0);
        if (t == 8) chk($sformatf("k2_r%0d_done_t8", r), {31'd0, done}, 32'd1);
        tick();
      end
      chk($sformatf("k2_r%0d_rdy", r), {31'd0, start_ready}, 32'd1);
    end
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    perf_exp = 32'd18;
`else
    perf_exp = 32'd0;
`endif
    chk("perf_two_k2", perf_cycles, perf_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, giving the number of PE rows (left-edge enable count).
REQ-002 The block SHALL have parameter COLS, default 4, giving the number of PE columns (top-edge enable count).
REQ-003 The block SHALL have parameter KW, default 8, giving the width of the k_len operand-length field.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  command request; sampled only while start_ready=1.
REQ-007 k_len  input  KW  number of operand steps K, sampled with accepted start.
REQ-008 abort  input  1  synchronous cancel of the running command.
REQ-009 start_ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 acc_clr  output  1  one-cycle accumulator-clear pulse at the start of a run.
REQ-013 row_en  output  ROWS  bit i drives the left-edge enleft of PE row i.
REQ-014 col_en  output  COLS  bit j drives the top-edge enabove of PE column j.
REQ-015 perf_cycles  output  32  busy-cycle counter (see Configuration).

Function
REQ-016 States SHALL be IDLE and RUN; a start accepted in IDLE with k_len!=0 SHALL move to RUN on the next cycle and latch K=k_len.
REQ-017 start with k_len==0 SHALL be ignored: the block stays in IDLE and no output changes.
REQ-018 start while not in IDLE SHALL be ignored.
REQ-019 In RUN an internal counter t SHALL equal 0 in the first RUN cycle and increment by 1 each cycle.
REQ-020 row_en[i] SHALL be 1 iff in RUN and i <= t < i+K; col_en[j] SHALL be 1 iff in RUN and j <= t < j+K.
REQ-021 The REQ-020 skew SHALL make the left and top enables coincide at every PE(i,j), active for i+j <= t < i+j+K.
REQ-022 acc_clr SHALL be 1 exactly in the cycle t=0.
REQ-023 done SHALL pulse for one cycle at t = ROWS+COLS+K-2, and the state SHALL return to IDLE in the following cycle.
REQ-024 busy SHALL be 1 from t=0 through the done cycle, inclusive.
REQ-025 t SHALL be wide enough (KW plus clog2(ROWS+COLS)+1 bits) never to wrap before done when K = 2^KW-1.
REQ-026 abort in RUN SHALL return the block to IDLE on the next cycle, with all row_en, col_en and busy low and no done pulse.
REQ-027 If abort and the done condition occur in the same cycle, done SHALL still pulse, because the command completed.
REQ-028 abort in IDLE SHALL have no effect, and abort SHALL take priority over a start in the same cycle.

Reset
REQ-029 While rst=1 on a clock edge, the block SHALL enter IDLE and clear t and K.
REQ-030 While rst=1 on a clock edge, row_en, col_en, busy, done and acc_clr SHALL be 0, start_ready SHALL be 1 and perf_cycles SHALL be 0.
REQ-031 rst asserted mid-RUN SHALL drop all enables on the next edge, with no done pulse.

Configuration
REQ-032 With macro SYSTOLIC_SEQ_PERF_CNT_EN defined, perf_cycles SHALL increment by 1 on every cycle with busy=1, saturate at 32'hFFFFFFFF, and clear only on rst.
REQ-033 Without SYSTOLIC_SEQ_PERF_CNT_EN, the perf_cycles port SHALL remain present and be tied to 0, and no counter logic SHALL be instantiated.

Verification
REQ-034 ROWS=COLS=4, start with k_len=3 -> acc_clr at t=0; row_en[0] high at t=0..2 and row_en[3] at t=3..5; col_en identical; done at t=9; start_ready high at t=10.
REQ-035 start with k_len=0 -> busy stays 0, no enables, no done, start_ready stays 1.
REQ-036 Second start at t=2 of a K=3 run -> ignored; done count equals 1; a new start after done is accepted.
REQ-037 abort at t=4 of a K=5 run -> all enables 0 from the next cycle, no done; a then-issued K=1 run gives done at t=7.
REQ-038 rst at t=3 -> outputs at reset values on the next edge, no done; with SYSTOLIC_SEQ_PERF_CNT_EN, perf_cycles=0.
REQ-039 With SYSTOLIC_SEQ_PERF_CNT_EN, two back-to-back K=2 runs on a 4x4 array -> perf_cycles=18.
